// File: rtl/mem_ctrl.sv
// CPU-side memory controller: decodes a 9-bit CPU address onto a synchronous RAM,
// an LED register and a switch port, and returns read responses with a valid/ready handshake.
module mem_ctrl #(
  parameter int         data_width = 16,
  parameter int         addr_width = 8,
  parameter logic [8:0] led_addr   = 9'h100,
  parameter logic [8:0] sw_addr    = 9'h140
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [8:0]            req_addr,
  input  logic [data_width-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [addr_width-1:0] ram_read_address,
  output logic [addr_width-1:0] ram_write_address,
  output logic                  ram_write,
  output logic [data_width-1:0] ram_din,
  input  logic [data_width-1:0] ram_dout,
  input  logic [7:0]            sw_in,
  output logic [7:0]            led_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic sel_ram, sel_led, sel_sw;
  logic accept;

  function automatic logic [data_width-1:0] zext8(input logic [7:0] v);
    logic [data_width-1:0] r;
    r      = '0;
    r[7:0] = v;
    return r;
  endfunction

  assign sel_ram = ~req_addr[8];
  assign sel_led = (req_addr == led_addr);
  assign sel_sw  = (req_addr == sw_addr);

  assign req_ready = (state == IDLE);
  assign accept    = req_ready & req_valid;
  assign rsp_valid = (state == RSP);

  // RAM ports follow the request bus directly; only the write enable is qualified.
  assign ram_read_address  = req_addr[addr_width-1:0];
  assign ram_write_address = req_addr[addr_width-1:0];
  assign ram_din           = req_data;
  assign ram_write         = accept & req_write & sel_ram & ~reset;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid && !req_write) state_nxt = sel_ram ? RD_WAIT : RSP;
      RD_WAIT: state_nxt = RSP;
      RSP:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response and LED registers; the response is only loaded on the way into RSP,
  // so it holds steady for as long as the CPU stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      led_out  <= 8'h00;
    end else begin
      if (state == RD_WAIT) begin
        rsp_data <= ram_dout;
        rsp_err  <= 1'b0;
      end else if (accept && !req_write && !sel_ram) begin
        if (sel_sw) begin
          rsp_data <= zext8(sw_in);
          rsp_err  <= 1'b0;
        end else if (sel_led) begin
          rsp_data <= zext8(led_out);
          rsp_err  <= 1'b0;
        end else begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
      if (accept && req_write && sel_led) led_out <= req_data[7:0];
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl with a behavioural RAM and a
// transaction-level model of the address map.
module tb_mem_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam logic [8:0] LED = 9'h100;
  localparam logic [8:0] SW  = 9'h140;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [8:0]    req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] ram_read_address, ram_write_address;
  logic          ram_write;
  logic [DW-1:0] ram_din, ram_dout;
  logic [7:0]    sw_in, led_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] ref_mem [0:255];
  logic [7:0]    ref_led;
  logic          ram_clr;
  logic [DW-1:0] ram [0:255];

  always #5 clk = ~clk;

  mem_ctrl #(.data_width(DW), .addr_width(AW), .led_addr(LED), .sw_addr(SW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
    .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout),
    .sw_in(sw_in), .led_out(led_out)
  );

  // Synchronous RAM with registered read port (read-before-write).
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (ram_write) begin
      ram[ram_write_address] <= ram_din;
    end
    ram_dout <= ram[ram_read_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {err, data} of a read, straight from the address map.
  function automatic logic [DW:0] model_read(input logic [8:0] a, input logic [7:0] sw);
    if (!a[8])   return {1'b0, ref_mem[a[7:0]]};
    if (a == SW) return {1'b0, 8'h00, sw};
    return {1'b1, {DW{1'b0}}};
  endfunction

  task automatic do_write(input logic [8:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_data = d;
    #1;
    check("wr_ready", 32'(req_ready), 32'd1);
    check("wr_ram_we", 32'(ram_write), 32'(!a[8]));
    @(posedge clk);
    #1 req_valid = 1'b0; req_write = 1'b0;
    if (!a[8]) ref_mem[a[7:0]] = d;
    else if (a == LED) ref_led = d[7:0];
    check("wr_led", 32'(led_out), 32'(ref_led));
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);
    check("wr_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [8:0] a, input int hold, input bit stress);
    logic [DW:0] e;
    int lat;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    #1;
    check("rd_ready", 32'(req_ready), 32'd1);
    check("rd_ram_we", 32'(ram_write), 32'd0);
    e = model_read(a, sw_in);
    @(posedge clk);
    #1 req_valid = 1'b0;
    rsp_ready = stress;
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    rsp_ready = 1'b0;
    check("rd_latency", 32'(lat), a[8] ? 32'd1 : 32'd2);
    check("rd_data", 32'(rsp_data), 32'(e[DW-1:0]));
    check("rd_err", 32'(rsp_err), 32'(e[DW]));
    for (int i = 0; i < hold; i++) begin
      if (stress) begin
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = {1'b0, 8'($urandom)}; req_data = DW'($urandom);
      end
      #1;
      check("bp_ram_we", 32'(ram_write), 32'd0);
      check("bp_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = 1'b0;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'(e[DW-1:0]));
      check("bp_err", 32'(rsp_err), 32'(e[DW]));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    check("hs_valid", 32'(rsp_valid), 32'd0);
    check("hs_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic reset_during(input bit in_rsp);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h005; rsp_ready = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    if (in_rsp) begin
      @(posedge clk); #1;
      check("rst_pre_rsp", 32'(rsp_valid), 32'd1);
    end else begin
      check("rst_pre_wait", 32'(rsp_valid), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    ref_led = 8'h00;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_data", 32'(rsp_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_stale", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    logic [8:0] a;
    reset = 1'b1; ram_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0; sw_in = 8'h00; ref_led = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_led_out", 32'(led_out), 32'd0);
    reset = 1'b0; ram_clr = 1'b0;
    @(negedge clk);
    check("rst_first_ready", 32'(req_ready), 32'd1);

    // Write then immediate read of the same RAM word.
    do_write(9'h005, 16'hBEEF);
    do_read(9'h005, 0, 1'b0);
    // Backpressure for five cycles.
    do_read(9'h005, 5, 1'b0);
    // LED and switch I/O.
    do_write(LED, 16'h00A5);
    sw_in = 8'h3C;
    do_read(SW, 2, 1'b0);
    // Unmapped accesses.
    do_read(9'h1FF, 1, 1'b0);
    do_write(9'h180, 16'h1234);
    do_write(SW, 16'h0077);
    // Reset mid-operation.
    do_write(LED, 16'h005A);
    reset_during(1'b0);
    do_write(LED, 16'h00C3);
    reset_during(1'b1);
    // Reset gating of the RAM write enable.
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h010; req_data = 16'hDEAD;
    #1;
    check("rst_gate_we", 32'(ram_write), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    do_read(9'h010, 0, 1'b0);

    for (int t = 0; t < 300; t++) begin
      case ($urandom % 4)
        0, 1: a = {1'b0, 8'($urandom_range(0, 15))};
        2:    a = ($urandom % 2) ? LED : SW;
        default: begin
          a = 9'h101 + 9'($urandom % 255);
          if (a == SW) a = 9'h1FF;
        end
      endcase
      sw_in = 8'($urandom);
      if ($urandom % 2) do_write(a, DW'($urandom));
      else if (a != LED) do_read(a, int'($urandom % 4), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters SHALL be: data_width, default 16, word width; addr_width, default 8, RAM address width; led_addr, default 9'h100, LED register address; sw_addr, default 9'h140, switch read address.
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  controller accepts a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  9  CPU address
- req_data  in  data_width  write data
- rsp_valid  out  1  read response held
- rsp_ready  in  1  CPU consumes the response
- rsp_data  out  data_width  read data
- rsp_err  out  1  response came from an unmapped address
- ram_read_address  out  addr_width  to RAM
- ram_write_address  out  addr_width  to RAM
- ram_write  out  1  RAM write enable
- ram_din  out  data_width  RAM write data
- ram_dout  in  data_width  registered RAM read data, valid 1 cycle after the address is sampled
- sw_in  in  8  switch inputs
- led_out  out  8  LED register
REQ-003 The block SHALL use the single clock clk, with reset synchronous and active-high; no other clock or async path.

Function
REQ-004 The block SHALL be an FSM with states IDLE, RD_WAIT and RSP.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted at an edge where req_valid and req_ready are both 1.
REQ-006 Address decode SHALL be: req_addr[8]==0 selects RAM at req_addr[addr_width-1:0]; req_addr==led_addr selects LED; req_addr==sw_addr selects SW; all other addresses are unmapped.
REQ-007 RAM addresses and data SHALL be driven combinationally: ram_read_address = ram_write_address = req_addr[addr_width-1:0] and ram_din = req_data at all times.
REQ-008 ram_write SHALL equal state==IDLE & req_valid & req_write & RAM-selected, so the RAM is written only at an accepting edge.
REQ-009 A RAM write SHALL complete at the accepting edge, produce no response, and leave the FSM in IDLE.
REQ-010 An LED write SHALL load led_out <= req_data[7:0] at the accepting edge and stay in IDLE.
REQ-011 A write to SW or to an unmapped address SHALL be accepted and ignored, with no response.
REQ-012 A RAM read SHALL be handled in three steps:
- IDLE -> RD_WAIT at the accepting edge E0; the RAM samples the address at E0.
- At E1: rsp_data <= ram_dout, rsp_err <= 0, go to RSP.
- rsp_valid is therefore 1 from E1: 2-cycle latency.
REQ-013 An SW read SHALL load rsp_data <= {zero-extend, sw_in} and rsp_err <= 0 at the accepting edge and go IDLE -> RSP: 1-cycle latency.
REQ-014 An unmapped read SHALL load rsp_data <= 0 and rsp_err <= 1 at the accepting edge and go IDLE -> RSP.
REQ-015 rsp_valid SHALL equal state==RSP; rsp_data and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-016 In RSP with rsp_ready=1, the FSM SHALL go to IDLE at that edge; req_ready stays 0 during that RSP cycle, so there is at most one outstanding read.
REQ-017 rsp_ready SHALL be ignored outside RSP.
REQ-018 A read accepted at the edge after a RAM write to the same address SHALL return the newly written data.
REQ-019 led_out SHALL change only on an LED write or on reset.

Reset
REQ-020 With reset=1 at an edge, the block SHALL set state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0 and led_out=0, regardless of state.
REQ-021 ram_write SHALL be 0 while reset=1, even if req_valid=1.
REQ-022 Reset in RD_WAIT or RSP SHALL discard the pending response, with no rsp_valid afterwards.
REQ-023 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-024 RAM write, then read:
- Stimulus: write 16'hBEEF to 9'h005, then read 9'h005 on the next cycle.
- Required: ram_write pulses for 1 cycle; rsp_valid rises 2 cycles after the read is accepted, with rsp_data=16'hBEEF and rsp_err=0.
REQ-025 Backpressure:
- Stimulus: RAM read with rsp_ready held 0 for 5 cycles, then 1.
- Required: rsp_valid and rsp_data stay stable for 5 cycles; IDLE the cycle after the handshake; req_ready=0 throughout.
REQ-026 Memory-mapped I/O:
- Stimulus: write 16'h00A5 to 9'h100; read 9'h140 with sw_in=8'h3C.
- Required: led_out=8'hA5; rsp_data=16'h003C after 1 cycle.
REQ-027 Unmapped access:
- Stimulus: read 9'h1FF; write to 9'h180.
- Required: the read returns rsp_data=0 and rsp_err=1; the write leaves ram_write=0 and led_out unchanged.
REQ-028 Reset mid-operation:
- Stimulus: assert reset during RD_WAIT, and again during RSP.
- Required: next cycle rsp_valid=0, led_out=0 and req_ready=1; no stale response appears.
REQ-029 Reset gating:
- Stimulus: reset=1 with req_valid=1 and req_write=1 to 9'h010.
- Required: ram_write=0 and memory unchanged.
